video_mem_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between the display fetch path and a host pixel writer (MCU/SPI loader).
- Display fetch is driven by DE and the pixel address generator's ADDR_H/ADDR_V outputs, and always wins the port.
- Host writes are buffered one-deep and committed only in cycles where DE is low.
- Sits between the VGA timing/address path, the frame-buffer RAM and the host loader.

---
 rtl/video_mem_arbiter_pkg.sv | 14 +
 rtl/video_mem_arbiter_wr_buffer.sv | 53 +++++
 rtl/video_mem_arbiter.sv | 103 ++++++++++
 tb/tb_video_mem_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mem_arbiter_pkg.sv
// Shared constants and port-state encoding for the frame-buffer arbiter.
package video_pkg;

    localparam int VIDEO_W  = 640;
    localparam int VIDEO_H  = 480;
    localparam int FB_DEPTH = VIDEO_W * VIDEO_H;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } port_state_t;

endpackage

// File: rtl/video_mem_arbiter_wr_buffer.sv
// One-deep host write holding register with accept/ACK handshake and range check.
module vmem_wr_buffer
    import video_pkg::*;
#(
    parameter int AW    = 19,
    parameter int DW    = 16,
    parameter int DEPTH = FB_DEPTH
) (
    input  logic          pclk,
    input  logic          reset_n,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    output logic          full,
    output logic [AW-1:0] buf_addr,
    output logic [DW-1:0] buf_data,
    output logic          wr_ack,
    output logic          wr_err
);

    // One extra bit so a frame that fills the whole address space still compares correctly.
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    logic accept;
    logic in_range;

    assign accept   = wr_req && (!full || commit);
    assign in_range = {1'b0, wr_addr} < LIMIT;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            full     <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
        end else begin
            wr_ack <= accept;
            if (accept && in_range) begin
                full     <= 1'b1;
                buf_addr <= wr_addr;
                buf_data <= wr_data;
            end else if (commit) begin
                full <= 1'b0;
            end
            if (accept && !in_range) begin
                wr_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_mem_arbiter.sv
// Frame-buffer port arbiter: display reads always win, host writes commit only while DE is low.
module video_mem_arbiter
    import video_pkg::*;
#(
    parameter int VIDEO_W = video_pkg::VIDEO_W,
    parameter int VIDEO_H = video_pkg::VIDEO_H,
    parameter int DW      = 16,
    parameter int AW      = 19
) (
    input  logic          PCLK,
    input  logic          RESET_N,
    input  logic          DE,
    input  logic [10:0]   ADDR_H,
    input  logic [9:0]    ADDR_V,
    input  logic          WR_REQ,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DATA,
    output logic          WR_ACK,
    output logic          WR_ERR,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [DW-1:0] PIX_DATA,
    output logic          PIX_VALID
);

    localparam int FB_SIZE = VIDEO_W * VIDEO_H;

    port_state_t   state;
    logic          buf_full;
    logic          commit;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic [AW-1:0] rd_addr;
    logic          pix_valid_q;
    logic [DW-1:0] pix_hold;

    assign rd_addr = AW'(ADDR_V) * AW'(VIDEO_W) + AW'(ADDR_H);
    assign commit  = !DE && buf_full;

    vmem_wr_buffer #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (FB_SIZE)
    ) u_wr_buffer (
        .pclk     (PCLK),
        .reset_n  (RESET_N),
        .wr_req   (WR_REQ),
        .wr_addr  (WR_ADDR),
        .wr_data  (WR_DATA),
        .commit   (commit),
        .full     (buf_full),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .wr_ack   (WR_ACK),
        .wr_err   (WR_ERR)
    );

    // A single decision per cycle owns the next memory slot, so read and write can never collide.
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            MEM_EN    <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
        end else if (DE) begin
            state    <= ST_RD;
            MEM_EN   <= 1'b1;
            MEM_WE   <= 1'b0;
            MEM_ADDR <= rd_addr;
        end else if (buf_full) begin
            state     <= ST_WR;
            MEM_EN    <= 1'b1;
            MEM_WE    <= 1'b1;
            MEM_ADDR  <= buf_addr;
            MEM_WDATA <= buf_data;
        end else begin
            state  <= ST_IDLE;
            MEM_EN <= 1'b0;
            MEM_WE <= 1'b0;
        end
    end

    // RAM data lands in the same cycle PIX_VALID rises; the hold register keeps the last pixel afterwards.
    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_valid_q <= 1'b0;
            pix_hold    <= '0;
        end else begin
            pix_valid_q <= (state == ST_RD);
            if (pix_valid_q) begin
                pix_hold <= MEM_RDATA;
            end
        end
    end

    assign PIX_VALID = pix_valid_q;
    assign PIX_DATA  = pix_valid_q ? MEM_RDATA : pix_hold;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Scenario bench for video_mem_arbiter with a pixel/write scoreboard and a behavioural RAM.
module tb_video_mem_arbiter;

    logic        PCLK;
    logic        RESET_N;
    logic        DE;
    logic [10:0] ADDR_H;
    logic [9:0]  ADDR_V;
    logic        WR_REQ;
    logic [18:0] WR_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_ACK;
    logic        WR_ERR;
    logic        MEM_EN;
    logic        MEM_WE;
    logic [18:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic [15:0] PIX_DATA;
    logic        PIX_VALID;

    int checks = 0;
    int errors = 0;

    logic        bd_we = 1'b0;
    int          bd_addr = 0;
    logic [15:0] bd_data = '0;

    logic [15:0] ram [int];
    logic [15:0] ref_mem [int];
    logic [15:0] pix_q [$];
    logic [34:0] wr_q [$];

    video_mem_arbiter dut (
        .PCLK      (PCLK),
        .RESET_N   (RESET_N),
        .DE        (DE),
        .ADDR_H    (ADDR_H),
        .ADDR_V    (ADDR_V),
        .WR_REQ    (WR_REQ),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .WR_ACK    (WR_ACK),
        .WR_ERR    (WR_ERR),
        .MEM_EN    (MEM_EN),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .PIX_DATA  (PIX_DATA),
        .PIX_VALID (PIX_VALID)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [15:0] pat(int a);
        return 16'(a * 37 + 11);
    endfunction

    function automatic logic [15:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    // Synchronous single-port RAM: read data appears the cycle after a read slot.
    always @(posedge PCLK) begin
        if (bd_we) begin
            ram[bd_addr] = bd_data;
        end else if (MEM_EN && MEM_WE) begin
            ram[int'(MEM_ADDR)] = MEM_WDATA;
        end
        if (MEM_EN && !MEM_WE) begin
            MEM_RDATA <= ram.exists(int'(MEM_ADDR)) ? ram[int'(MEM_ADDR)] : pat(int'(MEM_ADDR));
        end
    end

    task automatic test_reset();
        logic [55:0] obs;
        RESET_N = 1'b1; DE = 1'b0; ADDR_H = '0; ADDR_V = '0;
        WR_REQ = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        #2 RESET_N = 1'b0;
        #1 obs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, WR_ACK, WR_ERR, PIX_VALID, PIX_DATA};
        checks++;
        if (obs !== 56'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h, expected 0", obs);
        end
        repeat (3) @(negedge PCLK);
        RESET_N = 1'b1;
        @(negedge PCLK);
    endtask

    task automatic test_read_path();
        logic [15:0] e;
        @(negedge PCLK);
        bd_we = 1'b1; bd_addr = 1285; bd_data = 16'hABCD; ref_mem[1285] = 16'hABCD;
        @(negedge PCLK);
        bd_we = 1'b0; DE = 1'b1; ADDR_V = 10'd2; ADDR_H = 11'd5;
        pix_q.push_back(ref_rd(2 * 640 + 5));
        @(negedge PCLK);
        DE = 1'b0;
        checks++;
        if ({MEM_EN, MEM_WE} !== 2'b10) begin
            errors++; $display("[TB] FAIL rd_slot_en_we: got %b, expected 10", {MEM_EN, MEM_WE});
        end
        checks++;
        if (MEM_ADDR !== 19'd1285) begin
            errors++; $display("[TB] FAIL rd_addr: got %0d, expected 1285", MEM_ADDR);
        end
        checks++;
        if (PIX_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL rd_early_valid: got %b, expected 0", PIX_VALID);
        end
        @(negedge PCLK);
        checks++;
        if (PIX_VALID !== 1'b1 || pix_q.size() == 0) begin
            errors++; $display("[TB] FAIL rd_pix_valid: got %b, expected 1", PIX_VALID);
            e = 16'hABCD;
        end else begin
            e = pix_q.pop_front();
            checks++;
            if (PIX_DATA !== e) begin
                errors++; $display("[TB] FAIL rd_pix_data: got %h, expected %h", PIX_DATA, e);
            end
        end
        @(negedge PCLK);
        checks++;
        if (PIX_VALID !== 1'b0 || PIX_DATA !== e) begin
            errors++; $display("[TB] FAIL rd_pix_hold: got %b/%h, expected 0/%h", PIX_VALID, PIX_DATA, e);
        end
    endtask

    task automatic test_blanking_write();
        logic [34:0] w;
        @(negedge PCLK);
        DE = 1'b0; WR_REQ = 1'b1; WR_ADDR = 19'd100; WR_DATA = 16'h1234;
        wr_q.push_back({19'd100, 16'h1234});
        @(negedge PCLK);
        checks++;
        if (WR_ACK !== 1'b1) begin
            errors++; $display("[TB] FAIL blank_ack: got %b, expected 1", WR_ACK);
        end
        WR_REQ = 1'b0;
        ref_mem[100] = 16'h1234;
        @(negedge PCLK);
        checks++;
        if (WR_ACK !== 1'b0) begin
            errors++; $display("[TB] FAIL blank_ack_pulse: got %b, expected 0", WR_ACK);
        end
        checks++;
        if ({MEM_EN, MEM_WE} !== 2'b11 || wr_q.size() == 0) begin
            errors++; $display("[TB] FAIL blank_we: got %b, expected 11", {MEM_EN, MEM_WE});
        end else begin
            w = wr_q.pop_front();
            checks++;
            if ({MEM_ADDR, MEM_WDATA} !== w) begin
                errors++; $display("[TB] FAIL blank_wr_addr_data: got %h, expected %h", {MEM_ADDR, MEM_WDATA}, w);
            end
        end
        @(negedge PCLK);
        checks++;
        if (MEM_EN !== 1'b0 || MEM_ADDR !== 19'd100) begin
            errors++; $display("[TB] FAIL blank_idle_hold: got %b/%0d, expected 0/100", MEM_EN, MEM_ADDR);
        end
    endtask

    task automatic test_back_pressure();
        int acks = 0;
        int we_in_de = 0;
        logic [34:0] w;
        @(negedge PCLK);
        DE = 1'b1; ADDR_V = 10'd3; ADDR_H = 11'd0;
        WR_REQ = 1'b1; WR_ADDR = 19'd200; WR_DATA = 16'h1111;
        wr_q.push_back({19'd200, 16'h1111});
        for (int c = 1; c <= 640; c++) begin
            @(negedge PCLK);
            if (MEM_WE === 1'b1) we_in_de++;
            if (WR_ACK === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    ref_mem[200] = 16'h1111;
                    WR_ADDR = 19'd201; WR_DATA = 16'h2222;
                    wr_q.push_back({19'd201, 16'h2222});
                end
            end
            if (c < 640) begin
                ADDR_H = 11'(c);
            end else begin
                DE = 1'b0;
            end
        end
        checks++;
        if (acks != 1) begin
            errors++; $display("[TB] FAIL bp_ack_count: got %0d, expected 1", acks);
        end
        checks++;
        if (we_in_de != 0) begin
            errors++; $display("[TB] FAIL bp_we_during_de: got %0d, expected 0", we_in_de);
        end
        @(negedge PCLK);
        checks++;
        if (WR_ACK !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_second_ack: got %b, expected 1", WR_ACK);
        end
        WR_REQ = 1'b0;
        ref_mem[201] = 16'h2222;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (MEM_WE !== 1'b1 || wr_q.size() == 0) begin
                errors++; $display("[TB] FAIL bp_commit_%0d: got we=%b, expected 1", k, MEM_WE);
            end else begin
                w = wr_q.pop_front();
                checks++;
                if ({MEM_ADDR, MEM_WDATA} !== w) begin
                    errors++; $display("[TB] FAIL bp_commit_data_%0d: got %h, expected %h", k, {MEM_ADDR, MEM_WDATA}, w);
                end
            end
            @(negedge PCLK);
        end
        checks++;
        if (WR_ACK !== 1'b0 || MEM_EN !== 1'b0) begin
            errors++; $display("[TB] FAIL bp_settle: got ack=%b en=%b, expected 0/0", WR_ACK, MEM_EN);
        end
        @(negedge PCLK);
    endtask

    task automatic test_full_frame();
        int vlist[10] = '{0, 1, 2, 53, 120, 239, 240, 360, 478, 479};
        bit p1 = 1'b0;
        bit p2 = 1'b0;
        bit de;
        bit wr_busy = 1'b0;
        int a1 = 0;
        int a_cur;
        int wr_addr = 0;
        logic [15:0] wr_data = '0;
        logic [15:0] e;
        for (int li = 0; li < 10; li++) begin
            for (int c = 0; c < 659; c++) begin
                @(negedge PCLK);
                checks++;
                if (p1 && (MEM_EN !== 1'b1 || MEM_WE !== 1'b0 || MEM_ADDR !== 19'(a1))) begin
                    errors++; $display("[TB] FAIL ff_read_slot: got en=%b we=%b addr=%0d, expected 1/0/%0d", MEM_EN, MEM_WE, MEM_ADDR, a1);
                end
                checks++;
                if (PIX_VALID !== p2) begin
                    errors++; $display("[TB] FAIL ff_pix_valid: got %b, expected %b", PIX_VALID, p2);
                end
                if (PIX_VALID === 1'b1 && pix_q.size() > 0) begin
                    e = pix_q.pop_front();
                    checks++;
                    if (PIX_DATA !== e) begin
                        errors++; $display("[TB] FAIL ff_pix_data: got %h, expected %h (line %0d)", PIX_DATA, e, vlist[li]);
                    end
                end
                if (wr_busy && WR_ACK === 1'b1) begin
                    ref_mem[wr_addr] = wr_data;
                    wr_busy = 1'b0;
                end
                if (c == 16) begin
                    checks++;
                    if (wr_busy) begin
                        errors++; $display("[TB] FAIL ff_wr_ack_timeout: got no ack, expected ack (line %0d)", vlist[li]);
                        wr_busy = 1'b0;
                    end
                end
                de = (c >= 16) && (c < 656);
                a_cur = vlist[li] * 640 + (de ? c - 16 : 0);
                if (c == 1) begin
                    wr_busy = 1'b1;
                    wr_addr = vlist[li] * 640 + int'($urandom_range(0, 639));
                    wr_data = 16'($urandom);
                end
                DE = de;
                ADDR_V = 10'(vlist[li]);
                ADDR_H = de ? 11'(c - 16) : 11'd0;
                WR_REQ = wr_busy;
                WR_ADDR = 19'(wr_addr);
                WR_DATA = wr_data;
                if (de) pix_q.push_back(ref_rd(a_cur));
                p2 = p1; p1 = de; a1 = a_cur;
            end
        end
        checks++;
        if (pix_q.size() != 0) begin
            errors++; $display("[TB] FAIL ff_pix_drain: got %0d left, expected 0", pix_q.size());
        end
    endtask

    task automatic test_out_of_range();
        int we_seen = 0;
        @(negedge PCLK);
        DE = 1'b0; WR_REQ = 1'b1; WR_ADDR = 19'd307200; WR_DATA = 16'hDEAD;
        @(negedge PCLK);
        checks++;
        if (WR_ACK !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_ack: got %b, expected 1", WR_ACK);
        end
        WR_REQ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            if (MEM_WE === 1'b1) we_seen++;
        end
        checks++;
        if (we_seen != 0) begin
            errors++; $display("[TB] FAIL oor_no_write: got %0d writes, expected 0", we_seen);
        end
        checks++;
        if (WR_ERR !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_err: got %b, expected 1", WR_ERR);
        end
        WR_REQ = 1'b1; WR_ADDR = 19'd307199; WR_DATA = 16'h0505;
        @(negedge PCLK);
        WR_REQ = 1'b0;
        @(negedge PCLK);
        checks++;
        if (MEM_WE !== 1'b1 || MEM_ADDR !== 19'd307199 || MEM_WDATA !== 16'h0505) begin
            errors++; $display("[TB] FAIL last_addr_write: got we=%b addr=%0d data=%h, expected 1/307199/0505", MEM_WE, MEM_ADDR, MEM_WDATA);
        end
        checks++;
        if (WR_ERR !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_err_sticky: got %b, expected 1", WR_ERR);
        end
    endtask

    task automatic test_reset_midop();
        logic [55:0] obs;
        int bad = 0;
        @(negedge PCLK);
        DE = 1'b1; ADDR_V = 10'd7; ADDR_H = 11'd10;
        WR_REQ = 1'b1; WR_ADDR = 19'd300; WR_DATA = 16'h3333;
        @(negedge PCLK);
        checks++;
        if (WR_ACK !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_ack: got %b, expected 1", WR_ACK);
        end
        WR_REQ = 1'b0; ADDR_H = 11'd11;
        @(negedge PCLK);
        ADDR_H = 11'd12;
        #2 RESET_N = 1'b0;
        #1 obs = {MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, WR_ACK, WR_ERR, PIX_VALID, PIX_DATA};
        checks++;
        if (obs !== 56'd0) begin
            errors++; $display("[TB] FAIL mid_reset_outputs: got %h, expected 0", obs);
        end
        @(negedge PCLK);
        RESET_N = 1'b1; DE = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            if (WR_ACK !== 1'b0 || MEM_EN !== 1'b0 || MEM_WE !== 1'b0 || PIX_VALID !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL mid_discard: got %0d active cycles, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_read_path();
        test_blanking_write();
        test_back_pressure();
        test_full_frame();
        test_out_of_range();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
